// File: rtl/task_join_ctrl.sv
// task_join_ctrl: join controller for a bank of parallel worker engines.
// Launches a set of workers, tracks their done pulses and resolves the
// join (all / any / none) with an optional timeout. Any tracked workers
// still outstanding are killed before a completion record is returned.
// Workers launched in join-none mode stay detached: they are visible in
// 'running' until they finish or are aborted, but are never reported.

module task_join_ctrl #(
    parameter int N_WORK = 3,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [N_WORK-1:0] cmd_mask,
    input  logic [1:0]        cmd_mode,
    input  logic [TMO_W-1:0]  cmd_tmo,
    input  logic              abort,
    output logic [N_WORK-1:0] work_start,
    input  logic [N_WORK-1:0] work_done,
    output logic [N_WORK-1:0] work_kill,
    output logic [N_WORK-1:0] running,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N_WORK-1:0] rsp_finished,
    output logic [N_WORK-1:0] rsp_killed,
    output logic              rsp_timeout,
    output logic              rsp_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_KILL,
        ST_RESP
    } state_t;

    // Encoding 11 is reserved and behaves as join-all.
    typedef enum logic [1:0] {
        MODE_ALL  = 2'b00,
        MODE_ANY  = 2'b01,
        MODE_NONE = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    state_t             state;
    mode_t              mode_q;
    logic [N_WORK-1:0]  mask_q;
    logic               tmo_en_q;
    logic [TMO_W-1:0]   cnt_q;

    logic [N_WORK-1:0]  done_live;
    logic [N_WORK-1:0]  run_left;
    logic [N_WORK-1:0]  fin_next;
    logic [N_WORK-1:0]  survivors;
    logic               tracked;
    logic               join_met;
    logic               tmo_hit;

    // Per-cycle view of running/finished after this cycle's done pulses.
    always_comb begin
        // NOTE: every signal written here is assigned on every path (join_met
        // in both branches), so no latch can be inferred.
        done_live = work_done & running;
        run_left  = running & ~work_done;
        fin_next  = rsp_finished | (done_live & mask_q);
        survivors = mask_q & run_left;
        tracked   = (mode_q != MODE_NONE) && (mask_q != '0);
        if (mode_q == MODE_ANY) begin
            join_met = (fin_next != '0);
        end else begin
            join_met = (fin_next == mask_q);
        end
        // The counter holds tmo in the first WAIT cycle, so it reads 1 on
        // the tmo-th WAIT cycle.
        tmo_hit = tmo_en_q && (cnt_q == TMO_W'(1));
    end

    // Join FSM with registered strobes, running set and response record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state        <= ST_IDLE;
            mode_q       <= MODE_ALL;
            mask_q       <= '0;
            tmo_en_q     <= 1'b0;
            cnt_q        <= '0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            work_start   <= '0;
            work_kill    <= '0;
            running      <= '0;
            rsp_valid    <= 1'b0;
            rsp_finished <= '0;
            rsp_killed   <= '0;
            rsp_timeout  <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            // Strobes are single-cycle; a done on a running bit always
            // retires it, detached or tracked.
            work_start <= '0;
            work_kill  <= '0;
            running    <= run_left;

            // Abort kills whatever is still running after this cycle's
            // dones; a worker that finished in the same cycle is spared.
            if (abort) begin
                work_kill <= run_left;
                running   <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mask_q       <= cmd_mask;
                        mode_q       <= mode_t'(cmd_mode);
                        tmo_en_q     <= (cmd_tmo != '0);
                        // Loaded here; LAUNCH leaves it untouched, so the
                        // first WAIT cycle sees the full tmo value.
                        cnt_q        <= cmd_tmo;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        rsp_finished <= '0;
                        rsp_killed   <= '0;
                        rsp_timeout  <= 1'b0;
                        if ((cmd_mask & running) != '0) begin
                            // Overlap with live workers: refuse the launch.
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            rsp_err    <= 1'b0;
                            work_start <= cmd_mask;
                            state      <= ST_LAUNCH;
                        end
                    end
                end

                ST_LAUNCH: begin
                    // Launched bits only join 'running' at the end of this
                    // cycle, so a done coinciding with the start is ignored.
                    if (abort) begin
                        work_kill <= run_left | mask_q;
                        if (tracked) begin
                            rsp_killed <= mask_q;
                        end
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        running <= run_left | mask_q;
                        if (tracked) begin
                            state <= ST_WAIT;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end

                ST_WAIT: begin
                    rsp_finished <= fin_next;
                    if (abort) begin
                        rsp_killed <= survivors;
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
                    end else if (join_met || tmo_hit) begin
                        // Dones in the expiry cycle count first; the timeout
                        // flag is only raised if the join is still unmet.
                        if (survivors != '0) begin
                            work_kill   <= survivors;
                            rsp_killed  <= survivors;
                            running     <= run_left & ~mask_q;
                            rsp_timeout <= !join_met;
                            state       <= ST_KILL;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end else if (tmo_en_q) begin
                        cnt_q <= cnt_q - TMO_W'(1);
                    end
                end

                ST_KILL: begin
                    // Kill strobe is on the wire this cycle; report next.
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
